instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch stage sitting between the address register file and byte-wide instruction memory.
- Selects PC onto the address register file's OutD port, which drives the memory address.
- Performs two handshaked byte reads, increments PC after each read via RegSel/FunSel, and assembles a 16-bit instruction word for the decode/control unit.
- Has a timeout and flush path so a hung memory or a branch redirect cannot wedge the pipeline.

Parameters:
- LOW_BYTE_FIRST, 1: 1 = first fetched byte goes to ir[7:0] and second to ir[15:8]; 0 = reversed.
- MEM_TIMEOUT, 16: maximum cycles to wait for mem_valid per byte before aborting; legal range 2..255.

Ports:
- clock  input  1  rising-edge system clock
- reset_n  input  1  asynchronous active-low reset
- fetch_start  input  1  one-cycle request to fetch the next instruction; ignored unless busy=0
- flush  input  1  synchronous abort; highest priority after reset
- mem_rd_en  output  1  memory read request; held high until mem_valid
- mem_rdata  input  8  memory read data, valid when mem_valid=1
- mem_valid  input  1  memory read-complete strobe
- arf_regsel  output  3  to address register file RegSel: [2]=PC, [1]=SP, [0]=AR
- arf_funsel  output  2  to address register file FunSel; 2'b01 = increment
- arf_outdsel  output  2  to address register file OutDSel; 2'b00 = PC
- ir  output  16  assembled instruction word
- ir_valid  output  1  one-cycle pulse when ir is updated
- busy  output  1  high in every state except IDLE
- fetch_err  output  1  sticky; set on timeout, cleared by the next accepted fetch_start

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; ir=0; ir_valid=0; mem_rd_en=0; arf_regsel=0; arf_funsel=0; arf_outdsel=00; fetch_err=0.
  - Byte latch and timeout counter are cleared.
- arf_outdsel is held at 00 in all states, so OutD always tracks PC with one cycle of register latency.
- arf_regsel is 000 in every state except INC_LO and INC_HI. No other ARF register is ever written.
- State sequence and timing:
  - IDLE: on fetch_start=1, go to SETTLE_LO and clear fetch_err.
  - SETTLE_LO: 1 cycle, so that OutD holds the current PC.
  - REQ_LO:
    - mem_rd_en=1 and the timeout counter increments each cycle.
    - On mem_valid, latch mem_rdata as the first byte and go to INC_LO.
  - INC_LO: 1 cycle with arf_regsel=100 and arf_funsel=01, so PC+1 at the closing edge.
  - SETTLE_HI: 1 cycle; OutD captures the new PC.
  - REQ_HI: same as REQ_LO, latching the second byte.
  - INC_HI: 1 cycle with PC increment; at the closing edge, ir is written from the two bytes per LOW_BYTE_FIRST.
  - DONE: ir_valid=1 for exactly this cycle, then IDLE.
- Minimum latency with zero-wait memory (mem_valid in the first REQ cycle): fetch_start to ir_valid = 7 cycles.
- mem_rd_en drops in the cycle after mem_valid is sampled. A mem_valid arriving outside REQ_LO/REQ_HI is ignored.
- Timeout:
  - The counter resets on entry to each REQ state.
  - If it reaches MEM_TIMEOUT without mem_valid: fetch_err=1, mem_rd_en=0, go to IDLE.
  - ir is unchanged and no further PC increment occurs.
  - PC keeps any increment already applied: after a low-byte success and high-byte timeout, PC is +1.
- flush:
  - From any state, go to IDLE at the next edge with mem_rd_en=0 and arf_regsel=000.
  - ir and fetch_err are unchanged.
  - If flush coincides with INC_LO or INC_HI, that increment still completes, because RegSel is already asserted for the edge.
  - flush and fetch_start in the same IDLE cycle: flush wins and the start is dropped.
- fetch_start while busy=1 is ignored and not queued.
- Byte assembly is pure concatenation with no arithmetic. PC wrap at 16'hFFFF is the address register file's responsibility; this block is agnostic to it.
- reset_n deasserted mid-fetch: immediate return to IDLE. PC state is whatever the address register file holds.

Test Plan:
- Reset then fetch_start with PC=0x0010, mem[0x10]=0x34, mem[0x11]=0x12, zero wait:
  - ir_valid exactly 7 cycles after start; ir=0x1234; PC=0x0012.
  - arf_regsel=100 for exactly 2 cycles.
- Same memory contents with LOW_BYTE_FIRST=0 -> ir=0x3412.
- Memory returning mem_valid after 5 wait cycles on each byte -> ir_valid at cycle 17; mem_rd_en held continuously through each wait.
- Low byte OK, high byte never valid, MEM_TIMEOUT=16:
  - fetch_err=1 and busy=0 after 16 REQ_HI cycles; ir keeps its old value; PC=start+1.
  - The next fetch_start clears fetch_err.
- flush asserted in REQ_LO -> IDLE next cycle, mem_rd_en=0, PC unchanged, no ir_valid. flush asserted in INC_LO -> PC=start+1, IDLE.
- fetch_start pulsed during REQ_HI -> ignored, exactly one ir_valid. reset_n pulsed low in SETTLE_HI -> all outputs immediately at reset values.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: points the ARF OutD port at PC, reads two bytes through a
// handshaked byte memory, bumps PC after each byte and assembles a 16-bit word.
module instruction_fetch_unit #(
  parameter bit          LOW_BYTE_FIRST = 1'b1,
  parameter int unsigned MEM_TIMEOUT    = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fetch_start,
  input  logic        flush,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_valid,
  output logic [2:0]  arf_regsel,
  output logic [1:0]  arf_funsel,
  output logic [1:0]  arf_outdsel,
  output logic [15:0] ir,
  output logic        ir_valid,
  output logic        busy,
  output logic        fetch_err
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam logic [2:0]  SEL_NONE = 3'b000;
  localparam logic [2:0]  SEL_PC   = 3'b100;
  localparam logic [1:0]  FUN_HOLD = 2'b00;
  localparam logic [1:0]  FUN_INC  = 2'b01;
  localparam logic [1:0]  OUTD_PC  = 2'b00;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("instruction_fetch_unit: MEM_TIMEOUT must be in 2..255");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTLE_LO = 3'd1,
    REQ_LO    = 3'd2,
    INC_LO    = 3'd3,
    SETTLE_HI = 3'd4,
    REQ_HI    = 3'd5,
    INC_HI    = 3'd6,
    DONE      = 3'd7
  } state_t;

  state_t             state;
  logic [BYTE_W-1:0]  first_byte;
  logic [BYTE_W-1:0]  second_byte;
  logic [CNT_W-1:0]   wait_cnt;

  // OutD is permanently steered to PC; the memory address follows it.
  assign arf_outdsel = OUTD_PC;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      first_byte  <= '0;
      second_byte <= '0;
      wait_cnt    <= '0;
      mem_rd_en   <= 1'b0;
      arf_regsel  <= SEL_NONE;
      arf_funsel  <= FUN_HOLD;
      ir          <= '0;
      ir_valid    <= 1'b0;
      busy        <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      // Pulses and ARF controls default low every cycle.
      ir_valid   <= 1'b0;
      arf_regsel <= SEL_NONE;
      arf_funsel <= FUN_HOLD;

      if (flush) begin
        // An increment already on the ARF inputs completes on this edge anyway.
        state     <= IDLE;
        mem_rd_en <= 1'b0;
        busy      <= 1'b0;
        wait_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (fetch_start) begin
              state     <= SETTLE_LO;
              busy      <= 1'b1;
              fetch_err <= 1'b0;
            end
          end

          SETTLE_LO: begin
            state     <= REQ_LO;
            mem_rd_en <= 1'b1;
            wait_cnt  <= '0;
          end

          REQ_LO: begin
            if (mem_valid) begin
              first_byte <= mem_rdata;
              mem_rd_en  <= 1'b0;
              arf_regsel <= SEL_PC;
              arf_funsel <= FUN_INC;
              state      <= INC_LO;
            end else if (wait_cnt == TMO_LAST) begin
              mem_rd_en <= 1'b0;
              fetch_err <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end

          INC_LO: begin
            state <= SETTLE_HI;
          end

          SETTLE_HI: begin
            state     <= REQ_HI;
            mem_rd_en <= 1'b1;
            wait_cnt  <= '0;
          end

          REQ_HI: begin
            if (mem_valid) begin
              second_byte <= mem_rdata;
              mem_rd_en   <= 1'b0;
              arf_regsel  <= SEL_PC;
              arf_funsel  <= FUN_INC;
              state       <= INC_HI;
            end else if (wait_cnt == TMO_LAST) begin
              mem_rd_en <= 1'b0;
              fetch_err <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end

          INC_HI: begin
            if (LOW_BYTE_FIRST) begin
              ir <= {second_byte, first_byte};
            end else begin
              ir <= {first_byte, second_byte};
            end
            ir_valid <= 1'b1;
            state    <= DONE;
          end

          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end

          default: begin
            state     <= IDLE;
            mem_rd_en <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: two instances (low-byte-first and reversed)
// run in lockstep against a behavioural ARF PC register and wait-state memory.
module tb_instruction_fetch_unit;

  localparam int unsigned TMO = 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic fetch_start = 1'b0;
  logic flush = 1'b0;

  logic        mem_rd_en [2];
  logic [7:0]  mem_rdata [2];
  logic        mem_valid [2];
  logic [2:0]  regsel    [2];
  logic [1:0]  funsel    [2];
  logic [1:0]  outdsel   [2];
  logic [15:0] ir        [2];
  logic        irv       [2];
  logic        busy      [2];
  logic        ferr      [2];

  always #5 clock = ~clock;

  instruction_fetch_unit #(.LOW_BYTE_FIRST(1'b1), .MEM_TIMEOUT(TMO)) u_lbf1 (
    .clock(clock), .reset_n(reset_n), .fetch_start(fetch_start), .flush(flush),
    .mem_rd_en(mem_rd_en[0]), .mem_rdata(mem_rdata[0]), .mem_valid(mem_valid[0]),
    .arf_regsel(regsel[0]), .arf_funsel(funsel[0]), .arf_outdsel(outdsel[0]),
    .ir(ir[0]), .ir_valid(irv[0]), .busy(busy[0]), .fetch_err(ferr[0]));

  instruction_fetch_unit #(.LOW_BYTE_FIRST(1'b0), .MEM_TIMEOUT(TMO)) u_lbf0 (
    .clock(clock), .reset_n(reset_n), .fetch_start(fetch_start), .flush(flush),
    .mem_rd_en(mem_rd_en[1]), .mem_rdata(mem_rdata[1]), .mem_valid(mem_valid[1]),
    .arf_regsel(regsel[1]), .arf_funsel(funsel[1]), .arf_outdsel(outdsel[1]),
    .ir(ir[1]), .ir_valid(irv[1]), .busy(busy[1]), .fetch_err(ferr[1]));

  // Behavioural ARF (PC + registered OutD) and memory with programmable waits.
  logic [7:0]  mem [256];
  logic [15:0] pc   [2];
  logic [15:0] outd [2];
  int          wcnt   [2];
  int          grants [2];
  int          wait_cycles = 0;
  int          grant_limit = 1000;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = 16'h0000;
  logic        grant_load = 1'b0;
  int          cyc = 0;

  always_ff @(posedge clock) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (pc_load) pc[i] <= pc_load_val;
      else if (regsel[i][2] && funsel[i] == 2'b01) pc[i] <= pc[i] + 16'd1;
      outd[i] <= pc[i];
      if (mem_rd_en[i] && !mem_valid[i]) wcnt[i] <= wcnt[i] + 1;
      else wcnt[i] <= 0;
      if (grant_load) grants[i] <= grant_limit;
      else if (mem_valid[i]) grants[i] <= grants[i] - 1;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      mem_rdata[i] = mem[outd[i][7:0]];
      mem_valid[i] = mem_rd_en[i] && (wcnt[i] == wait_cycles) && (grants[i] > 0);
    end
  end

  typedef struct {
    logic [15:0] ir0;
    logic [15:0] ir1;
    logic [15:0] pc;
    int          lat;
    int          start;
  } exp_t;

  exp_t sb [$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every ir_valid and tallies handshake activity.
  int   rd_cycles = 0, rd_rises = 0, inc_cycles = 0, bad_sel = 0, irv_count = 0;
  logic rd_prev = 1'b0;

  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_rd_en[0]) rd_cycles++;
      if (mem_rd_en[0] && !rd_prev) rd_rises++;
      rd_prev = mem_rd_en[0];
      if (regsel[0] == 3'b100) inc_cycles++;
      else if (regsel[0] != 3'b000) bad_sel++;
      if (outdsel[0] != 2'b00 || outdsel[1] != 2'b00) bad_sel++;
      if (irv[0]) begin
        irv_count++;
        if (sb.size() == 0) begin
          check("unexpected_ir_valid", 32'(irv[0]), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ir_lbf1", 32'(ir[0]), 32'(e.ir0));
          check("ir_lbf0", 32'(ir[1]), 32'(e.ir1));
          check("latency", 32'(cyc - e.start), 32'(e.lat));
          check("pc_at_done", 32'(pc[0]), 32'(e.pc));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic start_fetch(input bit expect_done, input int lat);
    if (expect_done) begin
      exp_t e;
      logic [15:0] a;
      a = pc[0];
      e.ir0   = {mem[8'(a + 16'd1)], mem[8'(a)]};
      e.ir1   = {mem[8'(a)], mem[8'(a + 16'd1)]};
      e.pc    = a + 16'd2;
      e.lat   = lat;
      e.start = cyc;
      sb.push_back(e);
    end
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy[0] && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("idle_timeout", 32'(busy[0]), 32'd0);
  endtask

  task automatic load_grants(input int limit);
    grant_limit = limit;
    grant_load  = 1'b1;
    tick();
    grant_load  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap_a, snap_b, snap_c, c0;
    logic [15:0] pcs, ir_keep;

    for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37 + 11) & 8'hFF);
    mem[8'h10] = 8'h34;
    mem[8'h11] = 8'h12;

    // Reset state, PC preset to 0x0010.
    pc_load_val = 16'h0010;
    pc_load     = 1'b1;
    grant_load  = 1'b1;
    tick();
    tick();
    check("rst_ir",      32'(ir[0]), 32'd0);
    check("rst_ir_valid",32'(irv[0]), 32'd0);
    check("rst_rd_en",   32'(mem_rd_en[0]), 32'd0);
    check("rst_regsel",  32'(regsel[0]), 32'd0);
    check("rst_funsel",  32'(funsel[0]), 32'd0);
    check("rst_outdsel", 32'(outdsel[0]), 32'd0);
    check("rst_err",     32'(ferr[0]), 32'd0);
    check("rst_busy",    32'(busy[0]), 32'd0);
    pc_load    = 1'b0;
    grant_load = 1'b0;
    reset_n    = 1'b1;
    tick();

    // Zero-wait fetch.
    snap_a = inc_cycles;
    snap_b = irv_count;
    start_fetch(1'b1, 7);
    wait_idle(50);
    check("t1_ir_lbf1",    32'(ir[0]), 32'h1234);
    check("t1_ir_lbf0",    32'(ir[1]), 32'h3412);
    check("t1_pc",         32'(pc[0]), 32'h0012);
    check("t1_inc_cycles", 32'(inc_cycles - snap_a), 32'd2);
    check("t1_irv_count",  32'(irv_count - snap_b), 32'd1);

    // Five wait states per byte; read request held through each wait.
    wait_cycles = 5;
    snap_a = rd_cycles;
    snap_b = rd_rises;
    start_fetch(1'b1, 17);
    wait_idle(60);
    check("t2_rd_cycles", 32'(rd_cycles - snap_a), 32'd12);
    check("t2_rd_rises",  32'(rd_rises - snap_b), 32'd2);

    // High byte never returns: timeout after MEM_TIMEOUT REQ_HI cycles.
    wait_cycles = 0;
    load_grants(1);
    pcs     = pc[0];
    ir_keep = ir[0];
    snap_a  = rd_cycles;
    snap_b  = irv_count;
    c0      = cyc;
    start_fetch(1'b0, 0);
    wait_idle(80);
    check("tmo_busy_cycle", 32'(cyc - c0), 32'd21);
    check("tmo_err",        32'(ferr[0]), 32'd1);
    check("tmo_rd_en",      32'(mem_rd_en[0]), 32'd0);
    check("tmo_ir_kept",    32'(ir[0]), 32'(ir_keep));
    check("tmo_pc",         32'(pc[0]), 32'(pcs + 16'd1));
    check("tmo_rd_cycles",  32'(rd_cycles - snap_a), 32'd17);
    check("tmo_no_irv",     32'(irv_count - snap_b), 32'd0);
    load_grants(1000);

    // Next accepted start clears the sticky error.
    start_fetch(1'b1, 7);
    check("err_cleared", 32'(ferr[0]), 32'd0);
    wait_idle(50);

    // Flush while waiting in REQ_LO.
    wait_cycles = 100;
    pcs = pc[0];
    start_fetch(1'b0, 0);
    tick();
    check("fl1_rd_en_req", 32'(mem_rd_en[0]), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl1_busy",  32'(busy[0]), 32'd0);
    check("fl1_rd_en", 32'(mem_rd_en[0]), 32'd0);
    check("fl1_pc",    32'(pc[0]), 32'(pcs));

    // Flush during INC_LO: the increment still lands.
    wait_cycles = 0;
    pcs = pc[0];
    start_fetch(1'b0, 0);
    tick();
    tick();
    check("fl2_regsel_inc", 32'(regsel[0]), 32'b100);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl2_busy",   32'(busy[0]), 32'd0);
    check("fl2_pc",     32'(pc[0]), 32'(pcs + 16'd1));
    check("fl2_regsel", 32'(regsel[0]), 32'd0);

    // Flush beats a simultaneous start.
    flush = 1'b1;
    fetch_start = 1'b1;
    tick();
    flush = 1'b0;
    fetch_start = 1'b0;
    check("fl3_busy_a", 32'(busy[0]), 32'd0);
    tick();
    check("fl3_busy_b", 32'(busy[0]), 32'd0);

    // Start pulsed during REQ_HI is dropped.
    wait_cycles = 5;
    snap_c = irv_count;
    start_fetch(1'b1, 17);
    for (int i = 0; i < 9; i++) tick();
    check("busy_req_hi", 32'(mem_rd_en[0] && busy[0]), 32'd1);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    wait_idle(60);
    for (int i = 0; i < 10; i++) tick();
    check("ignored_start_busy", 32'(busy[0]), 32'd0);
    check("ignored_start_irv",  32'(irv_count - snap_c), 32'd1);

    // Async reset in SETTLE_HI.
    wait_cycles = 0;
    pcs = pc[0];
    start_fetch(1'b0, 0);
    tick();
    tick();
    tick();
    check("pre_rst_busy", 32'(busy[0]), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_ir",     32'(ir[0]), 32'd0);
    check("arst_busy",   32'(busy[0]), 32'd0);
    check("arst_irv",    32'(irv[0]), 32'd0);
    check("arst_rd_en",  32'(mem_rd_en[0]), 32'd0);
    check("arst_regsel", 32'(regsel[0]), 32'd0);
    check("arst_funsel", 32'(funsel[0]), 32'd0);
    check("arst_err",    32'(ferr[0]), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("post_rst_busy", 32'(busy[0]), 32'd0);
    check("post_rst_pc",   32'(pc[0]), 32'(pcs + 16'd1));

    check("sel_violations", 32'(bad_sel), 32'd0);
    check("sb_drained",     32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
